frame_dualport_mem: RTL and testbench
=====================================

Name: frame_dualport_mem

Overview:
- Parametrised simple dual-port RAM: one write port, one read port, for buffering one data frame between a producer and a consumer.
- Adds to a plain dual-port RAM:
  - registered read with a valid strobe;
  - per-address written tracking, so the frame is complete only when every address has been written;
  - a FILLING/READY state machine that write-protects a completed frame until the consumer clears it;
  - an error pulse for dropped writes.

Parameters:
- DATA_WIDTH, 32, width of each stored word.
- DEPTH, 16, number of memory locations.
- FRAME_LEN, 16, distinct addresses 0..FRAME_LEN-1 that make a complete frame; legal range 1..DEPTH.
- ADDR_WIDTH, $clog2(DEPTH), localparam, address width.
- CNT_WIDTH, $clog2(FRAME_LEN+1), localparam, width of wr_count.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- wea  in  1  write enable (port A)
- addra  in  ADDR_WIDTH  write address
- dina  in  DATA_WIDTH  write data
- reb  in  1  read enable (port B)
- addrb  in  ADDR_WIDTH  read address
- doutb  out  DATA_WIDTH  registered read data
- doutb_valid  out  1  doutb updated this cycle
- frame_clr  in  1  release the completed frame; restart filling
- frame_ready  out  1  all FRAME_LEN addresses written; frame locked
- wr_count  out  CNT_WIDTH  distinct frame addresses written so far
- wr_err  out  1  one-cycle pulse: a write was dropped

Behaviour:
- Reset: sampled on posedge clk while rst_n=0.
  - doutb=0, doutb_valid=0, frame_ready=0, wr_count=0, wr_err=0.
  - State FILLING; written-mark bitmap cleared.
  - Memory contents are not reset.
  - Reset asserted mid-frame discards all marks; the consumer must not use old data.
- States:
  - FILLING -> READY on the edge where wr_count becomes FRAME_LEN; frame_ready goes 1 on that same edge.
  - READY -> FILLING on frame_clr=1.
  - FILLING with frame_clr=1: marks and count cleared; stays FILLING.
- Writes in FILLING (wea=1):
  - addra < DEPTH: mem[addra] <= dina.
  - addra < FRAME_LEN and mark clear: set mark, wr_count += 1.
  - Rewriting an already-marked address updates data only; wr_count unchanged.
  - Address in FRAME_LEN..DEPTH-1: data stored, not counted.
- Writes in READY (frame_clr=0): dropped; memory unchanged; wr_err=1 next cycle.
- Out-of-range write (addra >= DEPTH, non-power-of-2 DEPTH): dropped; wr_err=1 next cycle.
- frame_clr together with wea in one cycle:
  - Clear takes priority, then the write is applied to the new frame.
  - Result: state FILLING, one mark set, wr_count=1 (0 if addra >= FRAME_LEN).
  - If FRAME_LEN=1 the new frame is complete immediately: READY, frame_ready=1.
- Reads:
  - Latency 1: reb=1 at edge N gives doutb=mem[addrb] and doutb_valid=1 after edge N.
  - reb=0: doutb holds its last value, doutb_valid=0.
  - Reads are legal in any state.
  - addrb >= DEPTH returns 0 with doutb_valid=1.
- Same-address read and write in one cycle: read-first; doutb returns the old word.
- wr_err is registered, high for exactly one cycle per dropped write.

Optional Feature:
- Macro FRAME_DUALPORT_MEM_WRITE_FIRST_EN.
- Defined: same-cycle same-address collision forwards dina to doutb (write-first bypass). Applies only if the write is actually accepted; a dropped write never bypasses.
- Undefined: read-first as above; no bypass logic.

Test Plan:
- Reset: rst_n=0 for 2 cycles after random activity -> doutb=0, doutb_valid=0, frame_ready=0, wr_count=0, wr_err=0.
- Fill frame, DEPTH=FRAME_LEN=16: write addr 0..15 with data 0x100+addr -> wr_count steps 1..16; frame_ready=1 on the edge of the 16th write; reading addr 5 returns 0x105 one cycle later with doutb_valid=1.
- Duplicate and locked writes:
  - Write addr 3 twice (0xA then 0xB) -> wr_count increments once; read returns 0xB.
  - Write addr 7 in READY -> wr_err=1 for one cycle; mem[7] unchanged.
- Clear with write: in READY, frame_clr=1 with wea=1, addra=2, dina=0x55 -> next cycle state FILLING, frame_ready=0, wr_count=1, mem[2]=0x55.
- Collision: write addr 4=0x77 while reading addr 4 (old 0x11) -> doutb=0x11; with FRAME_DUALPORT_MEM_WRITE_FIRST_EN defined, doutb=0x77.
- Out of range, DEPTH=12, FRAME_LEN=10:
  - Write addr 13 -> wr_err pulse, wr_count unchanged.
  - Read addr 14 -> doutb=0, doutb_valid=1.
  - Write addr 11 -> stored, not counted.

Source files
------------

// File: rtl/frame_dualport_mem.sv
// Simple dual-port frame buffer: one write port, one registered read port, per-address
// written tracking and a FILLING/READY lock. Define FRAME_DUALPORT_MEM_WRITE_FIRST_EN for write-first collisions.
module frame_dualport_mem #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 16,
  parameter int FRAME_LEN  = 16,
  localparam int ADDR_WIDTH = $clog2(DEPTH),
  localparam int CNT_WIDTH  = $clog2(FRAME_LEN + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wea,
  input  logic [ADDR_WIDTH-1:0] addra,
  input  logic [DATA_WIDTH-1:0] dina,
  input  logic                  reb,
  input  logic [ADDR_WIDTH-1:0] addrb,
  output logic [DATA_WIDTH-1:0] doutb,
  output logic                  doutb_valid,
  input  logic                  frame_clr,
  output logic                  frame_ready,
  output logic [CNT_WIDTH-1:0]  wr_count,
  output logic                  wr_err
);

  typedef enum logic {FILLING = 1'b0, READY = 1'b1} state_t;

  localparam logic [ADDR_WIDTH:0]  DEPTH_W   = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [CNT_WIDTH-1:0] FRAME_CNT = CNT_WIDTH'(FRAME_LEN);

  state_t                state_reg, state_next;
  logic [FRAME_LEN-1:0]  mark_reg, mark_next, mark_new;
  logic [CNT_WIDTH-1:0]  count_reg, count_next;
  logic [DATA_WIDTH-1:0] doutb_reg;
  logic                  doutb_valid_reg;
  logic                  wr_err_reg;
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic wr_in_range, rd_in_range, wr_accept, wr_drop;

  assign wr_in_range = {1'b0, addra} < DEPTH_W;
  assign rd_in_range = {1'b0, addrb} < DEPTH_W;
  // A clear in the same cycle reopens the frame, so the write lands in the new frame.
  assign wr_accept   = wea && wr_in_range && ((state_reg == FILLING) || frame_clr);
  assign wr_drop     = wea && !wr_accept;

  generate
    for (genvar gi = 0; gi < FRAME_LEN; gi++) begin : g_mark
      assign mark_new[gi]  = wr_accept && (addra == ADDR_WIDTH'(gi)) &&
                             (frame_clr || !mark_reg[gi]);
      assign mark_next[gi] = (mark_reg[gi] && !frame_clr) || mark_new[gi];
    end
  endgenerate

  always_comb begin
    count_next = frame_clr ? '0 : count_reg;
    if (|mark_new) begin
      count_next = count_next + CNT_WIDTH'(1);
    end
    state_next = (count_next == FRAME_CNT) ? READY : FILLING;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= FILLING;
    end else begin
      state_reg <= state_next;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mark_reg  <= '0;
      count_reg <= '0;
      wr_err_reg <= 1'b0;
    end else begin
      mark_reg  <= mark_next;
      count_reg <= count_next;
      wr_err_reg <= wr_drop;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_accept) begin
      mem[addra] <= dina;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      doutb_reg       <= '0;
      doutb_valid_reg <= 1'b0;
    end else begin
      doutb_valid_reg <= reb;
      if (reb) begin
`ifdef FRAME_DUALPORT_MEM_WRITE_FIRST_EN
        if (wr_accept && (addra == addrb)) begin
          doutb_reg <= dina;
        end else if (!rd_in_range) begin
          doutb_reg <= '0;
        end else begin
          doutb_reg <= mem[addrb];
        end
`else
        if (!rd_in_range) begin
          doutb_reg <= '0;
        end else begin
          doutb_reg <= mem[addrb];
        end
`endif
      end
    end
  end

  assign doutb       = doutb_reg;
  assign doutb_valid = doutb_valid_reg;
  assign frame_ready = (state_reg == READY);
  assign wr_count    = count_reg;
  assign wr_err      = wr_err_reg;

endmodule

// File: tb/tb_frame_dualport_mem.sv
// Directed bench for frame_dualport_mem: a 16/16 instance and a 12/10 instance
// for out-of-range and non-frame addresses.
module tb_frame_dualport_mem;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // instance A: DEPTH=16, FRAME_LEN=16
  logic        wea, reb, frame_clr;
  logic [3:0]  addra, addrb;
  logic [31:0] dina, doutb;
  logic        doutb_valid, frame_ready, wr_err;
  logic [4:0]  wr_count;

  // instance B: DEPTH=12, FRAME_LEN=10
  logic        wea_b, reb_b, frame_clr_b;
  logic [3:0]  addra_b, addrb_b;
  logic [31:0] dina_b, doutb_b;
  logic        doutb_valid_b, frame_ready_b, wr_err_b;
  logic [3:0]  wr_count_b;

  int checks = 0;
  int errors = 0;

  frame_dualport_mem #(.DATA_WIDTH(32), .DEPTH(16), .FRAME_LEN(16)) dut (
    .clk(clk), .rst_n(rst_n), .wea(wea), .addra(addra), .dina(dina),
    .reb(reb), .addrb(addrb), .doutb(doutb), .doutb_valid(doutb_valid),
    .frame_clr(frame_clr), .frame_ready(frame_ready), .wr_count(wr_count),
    .wr_err(wr_err)
  );

  frame_dualport_mem #(.DATA_WIDTH(32), .DEPTH(12), .FRAME_LEN(10)) dut_b (
    .clk(clk), .rst_n(rst_n), .wea(wea_b), .addra(addra_b), .dina(dina_b),
    .reb(reb_b), .addrb(addrb_b), .doutb(doutb_b), .doutb_valid(doutb_valid_b),
    .frame_clr(frame_clr_b), .frame_ready(frame_ready_b), .wr_count(wr_count_b),
    .wr_err(wr_err_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end else begin
      $display("ok   %s: got=%0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wea = 1'b0; reb = 1'b0; frame_clr = 1'b0; addra = '0; addrb = '0; dina = '0;
    wea_b = 1'b0; reb_b = 1'b0; frame_clr_b = 1'b0; addra_b = '0; addrb_b = '0; dina_b = '0;
  endtask

  task automatic write_a(input logic [3:0] a, input logic [31:0] d);
    wea = 1'b1; addra = a; dina = d;
    tick();
    wea = 1'b0;
  endtask

  task automatic read_a(input logic [3:0] a, input logic [31:0] exp, input string tag);
    reb = 1'b1; addrb = a;
    tick();
    reb = 1'b0;
    check(tag, doutb, exp);
    check({tag, "_valid"}, {31'b0, doutb_valid}, 32'd1);
  endtask

  task automatic write_b(input logic [3:0] a, input logic [31:0] d);
    wea_b = 1'b1; addra_b = a; dina_b = d;
    tick();
    wea_b = 1'b0;
  endtask

  task automatic read_b(input logic [3:0] a, input logic [31:0] exp, input string tag);
    reb_b = 1'b1; addrb_b = a;
    tick();
    reb_b = 1'b0;
    check(tag, doutb_b, exp);
    check({tag, "_valid"}, {31'b0, doutb_valid_b}, 32'd1);
  endtask

  initial begin
    idle();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;

    // random activity, then a two-cycle reset with reads still requested
    for (int i = 0; i < 8; i++) begin
      wea = 1'($urandom_range(0, 1)); addra = 4'($urandom); dina = $urandom;
      reb = 1'b1; addrb = 4'($urandom); frame_clr = 1'($urandom_range(0, 1));
      tick();
    end
    idle();
    reb = 1'b1;
    rst_n = 1'b0;
    tick();
    tick();
    reb = 1'b0;
    check("rst_doutb", doutb, 32'h0);
    check("rst_valid", {31'b0, doutb_valid}, 32'd0);
    check("rst_ready", {31'b0, frame_ready}, 32'd0);
    check("rst_count", {27'b0, wr_count}, 32'd0);
    check("rst_err", {31'b0, wr_err}, 32'd0);
    rst_n = 1'b1;
    tick();

    // fill the whole frame
    for (int a = 0; a < 16; a++) begin
      write_a(4'(a), 32'h100 + 32'(a));
      check($sformatf("fill_count_%0d", a), {27'b0, wr_count}, 32'(a + 1));
      check($sformatf("fill_ready_%0d", a), {31'b0, frame_ready}, (a == 15) ? 32'd1 : 32'd0);
    end
    read_a(4'd5, 32'h105, "rd5");
    tick();
    check("rd_idle_valid", {31'b0, doutb_valid}, 32'd0);
    check("rd_idle_hold", doutb, 32'h105);

    // locked write
    write_a(4'd7, 32'hDEAD);
    check("locked_err", {31'b0, wr_err}, 32'd1);
    check("locked_count", {27'b0, wr_count}, 32'd16);
    tick();
    check("locked_err_pulse", {31'b0, wr_err}, 32'd0);
    read_a(4'd7, 32'h107, "locked_mem7");

    // clear together with a write
    frame_clr = 1'b1;
    write_a(4'd2, 32'h55);
    frame_clr = 1'b0;
    check("clrw_ready", {31'b0, frame_ready}, 32'd0);
    check("clrw_count", {27'b0, wr_count}, 32'd1);
    check("clrw_err", {31'b0, wr_err}, 32'd0);
    read_a(4'd2, 32'h55, "clrw_mem2");

    // duplicate address
    write_a(4'd3, 32'hA);
    check("dup1_count", {27'b0, wr_count}, 32'd2);
    write_a(4'd3, 32'hB);
    check("dup2_count", {27'b0, wr_count}, 32'd2);
    read_a(4'd3, 32'hB, "dup_mem3");

    // same-address collision
    write_a(4'd4, 32'h11);
    check("coll_pre_count", {27'b0, wr_count}, 32'd3);
    reb = 1'b1; addrb = 4'd4;
    write_a(4'd4, 32'h77);
    reb = 1'b0;
`ifdef FRAME_DUALPORT_MEM_WRITE_FIRST_EN
    check("coll_doutb", doutb, 32'h77);
`else
    check("coll_doutb", doutb, 32'h11);
`endif
    check("coll_count", {27'b0, wr_count}, 32'd3);
    read_a(4'd4, 32'h77, "coll_mem4");

    // clear alone while filling
    frame_clr = 1'b1;
    tick();
    frame_clr = 1'b0;
    check("clr_count", {27'b0, wr_count}, 32'd0);
    check("clr_ready", {31'b0, frame_ready}, 32'd0);

    // DEPTH=12, FRAME_LEN=10 instance
    write_b(4'd13, 32'h1313);
    check("b_oor_err", {31'b0, wr_err_b}, 32'd1);
    check("b_oor_count", {28'b0, wr_count_b}, 32'd0);
    tick();
    check("b_oor_err_pulse", {31'b0, wr_err_b}, 32'd0);
    write_b(4'd11, 32'hBEEF);
    check("b_a11_err", {31'b0, wr_err_b}, 32'd0);
    check("b_a11_count", {28'b0, wr_count_b}, 32'd0);
    read_b(4'd11, 32'hBEEF, "b_rd11");
    read_b(4'd14, 32'h0, "b_rd14");
    for (int a = 0; a < 10; a++) begin
      write_b(4'(a), 32'h200 + 32'(a));
    end
    check("b_fill_count", {28'b0, wr_count_b}, 32'd10);
    check("b_fill_ready", {31'b0, frame_ready_b}, 32'd1);
    read_b(4'd9, 32'h209, "b_rd9");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
